score_collector: RTL and testbench

SCORE_COLLECTOR -- requirements
Module: score_collector

---
 rtl/score_collector.sv | 149 ++++++++++++++
 tb/tb_score_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_collector.sv
// score_collector: buffers serialized scores in a FIFO and tags each entry
// with its weight index within the group (0..NUM_WEIGHTS-1) and a
// last-of-group flag.
// Optional macro SCORE_ARGMIN_EN adds a per-group minimum/argmin tracker.
// Without it, the best_* outputs are tied to zero.
module score_collector #(
    parameter int NUM_WEIGHTS = 400,
    parameter int DEPTH       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [8:0]  m_idx,
    output logic        m_last,
    output logic        overflow,
    output logic        best_valid,
    output logic [31:0] best_val,
    output logic [8:0]  best_idx
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = 9;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WEIGHTS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0]   data;
        logic [IW-1:0] idx;
        logic          last;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [IW-1:0]   r_wr_idx;
    logic            r_overflow;

    logic            w_wr;
    logic            w_rd;
    logic            w_wr_last;
    entry_t          w_head;

    // A full FIFO refuses writes even if a pop happens in the same cycle.
    assign in_ready  = (r_count != FULL_CNT);
    assign m_valid   = (r_count != '0);
    assign w_wr      = in_valid && in_ready;
    assign w_rd      = m_valid && m_ready;
    assign w_wr_last = (r_wr_idx == LAST_IDX);
    assign w_head    = r_mem[r_rd_ptr];
    assign m_data    = w_head.data;
    assign m_idx     = w_head.idx;
    assign m_last    = w_head.last;
    assign overflow  = r_overflow;

    // Storage array: no reset needed, every read is qualified by m_valid.
    always_ff @(posedge clk) begin
        if (w_wr && !clear)
            r_mem[r_wr_ptr] <= '{data: in_data, idx: r_wr_idx, last: w_wr_last};
    end

    // Pointers, occupancy, group index and sticky overflow; clear wins over traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_idx   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_idx   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
            end
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_valid && !in_ready)
                r_overflow <= 1'b1;
        end
    end

`ifdef SCORE_ARGMIN_EN
    logic [31:0]   r_min_val;
    logic [IW-1:0] r_min_idx;
    logic          r_best_valid;
    logic [31:0]   r_best_val;
    logic [IW-1:0] r_best_idx;
    logic          w_take;
    logic [31:0]   w_min_val;
    logic [IW-1:0] w_min_idx;

    // Index 0 restarts the running minimum; strict less-than keeps the earliest tie.
    assign w_take    = (r_wr_idx == '0) || (in_data < r_min_val);
    assign w_min_val = w_take ? in_data  : r_min_val;
    assign w_min_idx = w_take ? r_wr_idx : r_min_idx;

    // Running min over accepted writes; publish and pulse on the group's last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min_val    <= '0;
            r_min_idx    <= '0;
            r_best_valid <= 1'b0;
            r_best_val   <= '0;
            r_best_idx   <= '0;
        end else if (clear) begin
            r_min_val    <= '0;
            r_min_idx    <= '0;
            r_best_valid <= 1'b0;
            r_best_val   <= '0;
            r_best_idx   <= '0;
        end else begin
            r_best_valid <= w_wr && w_wr_last;
            if (w_wr) begin
                r_min_val <= w_min_val;
                r_min_idx <= w_min_idx;
                if (w_wr_last) begin
                    r_best_val <= w_min_val;
                    r_best_idx <= w_min_idx;
                end
            end
        end
    end

    assign best_valid = r_best_valid;
    assign best_val   = r_best_val;
    assign best_idx   = r_best_idx;
`else
    assign best_valid = 1'b0;
    assign best_val   = '0;
    assign best_idx   = '0;
`endif

endmodule

// File: tb/tb_score_collector.sv
// Bench for score_collector (NUM_WEIGHTS=4, DEPTH=16). A reference model at
// each falling edge checks handshakes and the head entry against a
// scoreboard queue. Group minima come from a stimulus table, and
// hand-written sequences exercise full, clear and reset behavior.
module tb_score_collector;
    localparam int NW  = 4;
    localparam int DEP = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [8:0]  m_idx;
    logic        m_last;
    logic        overflow;
    logic        best_valid;
    logic [31:0] best_val;
    logic [8:0]  best_idx;

    int n_tests = 0;
    int n_fail  = 0;

    score_collector #(.NUM_WEIGHTS(NW), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_idx(m_idx), .m_last(m_last), .overflow(overflow),
        .best_valid(best_valid), .best_val(best_val), .best_idx(best_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [8:0]  i;
        logic        l;
    } ent_t;

    ent_t        q[$];
    int          mcount;
    int          mwidx;
    logic        movf;
    logic [31:0] mmin;
    int          mminidx;
    logic        ebv;
    logic [31:0] ebval;
    int          ebidx;

    initial begin : model
        logic acc, pop;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mcount = 0; mwidx = 0; movf = 1'b0;
                mmin = '0; mminidx = 0; ebv = 1'b0; ebval = '0; ebidx = 0;
                q.delete();
            end
            check("in_ready",   64'(in_ready),   64'(mcount != DEP));
            check("m_valid",    64'(m_valid),    64'(mcount != 0));
            check("overflow",   64'(overflow),   64'(movf));
            check("best_valid", 64'(best_valid), 64'(ebv));
            check("best_val",   64'(best_val),   64'(ebval));
            check("best_idx",   64'(best_idx),   64'(ebidx));
            if (mcount != 0 && q.size() > 0) begin
                check("m_data", 64'(m_data), 64'(q[0].d));
                check("m_idx",  64'(m_idx),  64'(q[0].i));
                check("m_last", 64'(m_last), 64'(q[0].l));
            end
            if (rst_n) begin
                if (clear) begin
                    mcount = 0; mwidx = 0; movf = 1'b0;
                    mmin = '0; mminidx = 0; ebv = 1'b0; ebval = '0; ebidx = 0;
                    q.delete();
                end else begin
                    acc = in_valid && (mcount != DEP);
                    pop = m_ready && (mcount != 0);
                    if (in_valid && !acc) movf = 1'b1;
                    if (pop) void'(q.pop_front());
`ifdef SCORE_ARGMIN_EN
                    ebv = 1'b0;
                    if (acc) begin
                        if (mwidx == 0 || in_data < mmin) begin
                            mmin = in_data; mminidx = mwidx;
                        end
                        if (mwidx == NW - 1) begin
                            ebv = 1'b1; ebval = mmin; ebidx = mminidx;
                        end
                    end
`endif
                    if (acc) begin
                        q.push_back('{d: in_data, i: 9'(mwidx), l: (mwidx == NW - 1)});
                        mwidx = (mwidx == NW - 1) ? 0 : mwidx + 1;
                    end
                    mcount = mcount + int'(acc) - int'(pop);
                end
            end
        end
    end

    // ---------------- group table ----------------
    typedef struct {
        logic [31:0] s0, s1, s2, s3;
        logic [31:0] bval;
        logic [8:0]  bidx;
    } row_t;

    row_t rows[5];

    function automatic logic [31:0] pick(input row_t r, input int j);
        case (j)
            0:       return r.s0;
            1:       return r.s1;
            2:       return r.s2;
            default: return r.s3;
        endcase
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic check_best(input string name, input logic [31:0] v, input logic [8:0] i);
`ifdef SCORE_ARGMIN_EN
        check({name, "_valid"}, 64'(best_valid), 64'd1);
        check({name, "_val"},   64'(best_val),   64'(v));
        check({name, "_idx"},   64'(best_idx),   64'(i));
`else
        check({name, "_valid"}, 64'(best_valid), 64'd0);
        check({name, "_val"},   64'(best_val),   64'd0);
        check({name, "_idx"},   64'(best_idx),   64'd0);
`endif
    endtask

    initial begin : stim
        int n;
        rows[0] = '{s0: 9,  s1: 3, s2: 7, s3: 3, bval: 3, bidx: 1};
        rows[1] = '{s0: 5,  s1: 6, s2: 7, s3: 8, bval: 5, bidx: 0};
        rows[2] = '{s0: 4,  s1: 4, s2: 4, s3: 4, bval: 4, bidx: 0};
        rows[3] = '{s0: 10, s1: 9, s2: 8, s3: 1, bval: 1, bidx: 3};
        rows[4] = '{s0: 32'hFFFF_FFFF, s1: 0, s2: 0, s3: 5, bval: 0, bidx: 1};

        // reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_m_valid",  64'(m_valid),  64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_best",     {best_valid, best_val, best_idx}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single write on an empty FIFO, consumer ready
        m_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00AA;
        tick();
        in_valid = 1'b0;
        check("one_m_valid", 64'(m_valid), 64'd1);
        check("one_m_data",  64'(m_data),  64'h0000_00AA);
        check("one_m_idx",   64'(m_idx),   64'd0);
        check("one_m_last",  64'(m_last),  64'd0);
        tick();
        check("one_empty",   64'(m_valid), 64'd0);

        // back-to-back groups from the table
        do_clear();
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                in_valid = 1'b1; in_data = pick(rows[r], j);
                tick();
            end
            check_best($sformatf("tbl%0d_best", r), rows[r].bval, rows[r].bidx);
        end
        in_valid = 1'b0;
        tick();
        tick();

        // fill with consumer stalled, 17th write dropped, then clear
        do_clear();
        m_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(k);
            tick();
            if (k == 15) check("full_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check("full_overflow", 64'(overflow), 64'd1);
        check("full_m_valid",  64'(m_valid),  64'd1);
        do_clear();
        check("clr_overflow", 64'(overflow), 64'd0);
        check("clr_m_valid",  64'(m_valid),  64'd0);
        check("clr_in_ready", 64'(in_ready), 64'd1);

        // full FIFO: pop and write in the same cycle; write must be dropped
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 32'h200 + 32'(k);
            tick();
        end
        m_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        tick();
        in_valid = 1'b0;
        check("popw_overflow", 64'(overflow), 64'd1);
        check("popw_in_ready", 64'(in_ready), 64'd1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!m_valid) break;
            n++;
            tick();
        end
        check("popw_count", 64'(n), 64'd15);

        // clear overrides a simultaneous write and pop
        in_valid = 1'b1; in_data = 32'h33;
        tick();
        clear = 1'b1; in_data = 32'h44;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clrovr_m_valid", 64'(m_valid), 64'd0);

        // reset partway through a group
        in_valid = 1'b1; in_data = 32'd100;
        tick();
        in_data = 32'd1;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("mid_rst_m_valid",  64'(m_valid),  64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1; in_data = 32'd5 + 32'(j);
            tick();
            if (j == 0) check("mid_rst_idx0", 64'(m_idx), 64'd0);
        end
        in_valid = 1'b0;
        check_best("mid_rst_best", 32'd5, 9'd0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
